// File: rtl/gray_control.sv
// gray_control: converts RGB555 capture pixels to 5-bit luma and writes {Y,Y,Y} to the gray buffer.
//
// Ports:
//   gray_clk        stage clock, forwarded to both buffers as read_clk / write_clk
//   reset_n         asynchronous active-low reset
//   ack_read        capture-buffer grant      rq_read   capture-buffer request
//   reading         rq_read & ack_read        read_addr capture-buffer address
//   input_px_rgb    R[14:10] G[9:5] B[4:0], valid one cycle after read_addr
//   ack_write       gray-buffer grant         rq_write  gray-buffer request
//   writing         rq_write & ack_write      write_en  gray-buffer write strobe
//   output_px_gray  {Y,Y,Y}                   write_addr gray-buffer address
//   enable_mem      high while the stage owns both buffers
//   frame_done      one-cycle pulse when a frame completes
//   peak_luma       maximum Y of the last completed frame
//
// Optional feature macro: GRAY_PEAK_EN enables per-frame peak luma tracking;
// without it peak_luma is tied to 0.
module gray_control #(
  parameter int DEPTH     = 76800,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 gray_clk,
  input  logic                 reset_n,
  input  logic                 ack_read,
  output logic                 rq_read,
  output logic                 reading,
  input  logic [14:0]          input_px_rgb,
  output logic [ADDR_BITS-1:0] read_addr,
  output logic                 read_clk,
  input  logic                 ack_write,
  output logic                 rq_write,
  output logic                 writing,
  output logic [14:0]          output_px_gray,
  output logic [ADDR_BITS-1:0] write_addr,
  output logic                 write_en,
  output logic                 write_clk,
  output logic                 enable_mem,
  output logic                 frame_done,
  output logic [4:0]           peak_luma
);
  typedef enum logic [2:0] {IDLE, REQUEST, PROCESS, FLUSH, DONE} state_t;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);
  state_t state, state_nx;
  logic flush_cnt;
  logic rd_valid;
  logic [ADDR_BITS-1:0] rd_addr;
  logic granted, active, abort;
  logic [12:0] sum;
  logic [4:0] luma;
  assign granted   = ack_read & ack_write;
  assign active    = (state == PROCESS) || (state == FLUSH);
  assign abort     = active && !granted;
  assign rq_read   = (state == REQUEST) || active;
  assign rq_write  = rq_read;
  assign reading   = rq_read & ack_read;
  assign writing   = rq_write & ack_write;
  assign frame_done = state == DONE;
  assign read_clk  = gray_clk;
  assign write_clk = gray_clk;
  // 77+150+29 = 256, so the sum never exceeds 31*256 and the top 5 bits are Y
  assign sum  = 13'd77 * 13'(input_px_rgb[14:10]) + 13'd150 * 13'(input_px_rgb[9:5]) + 13'd29 * 13'(input_px_rgb[4:0]);
  assign luma = sum[12:8];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (!ack_read && !ack_write) ? REQUEST : IDLE;
      REQUEST: state_nx = granted ? PROCESS : REQUEST;
      PROCESS: state_nx = !granted ? IDLE : (read_addr == LAST) ? FLUSH : PROCESS;
      FLUSH:   state_nx = !granted ? IDLE : flush_cnt ? DONE : FLUSH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge gray_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      flush_cnt      <= 1'b0;
      read_addr      <= '0;
      enable_mem     <= 1'b0;
      rd_valid       <= 1'b0;
      rd_addr        <= '0;
      write_en       <= 1'b0;
      write_addr     <= '0;
      output_px_gray <= '0;
    end else begin
      state      <= state_nx;
      flush_cnt  <= (state == FLUSH) && (state_nx == FLUSH);
      // read address holds at LAST through FLUSH and is zero everywhere outside a frame
      read_addr  <= (state == PROCESS && granted && read_addr != LAST) ? read_addr + ADDR_BITS'(1) :
                    (state_nx == FLUSH) ? read_addr : '0;
      enable_mem <= (state_nx == PROCESS) || (state_nx == FLUSH);
      rd_valid   <= (state == PROCESS) && granted;
      rd_addr    <= read_addr;
      write_en   <= rd_valid && !abort;
      write_addr <= abort ? '0 : rd_valid ? rd_addr : (state == DONE) ? '0 : write_addr;
      output_px_gray <= (rd_valid && !abort) ? {luma, luma, luma} : output_px_gray;
    end
  end
`ifdef GRAY_PEAK_EN
  logic [4:0] run_max;
  always_ff @(posedge gray_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_max   <= '0;
      peak_luma <= '0;
    end else begin
      run_max   <= (abort || state == DONE) ? '0 :
                   (write_en && output_px_gray[4:0] > run_max) ? output_px_gray[4:0] : run_max;
      peak_luma <= (state == DONE) ? run_max : peak_luma;
    end
  end
`else
  assign peak_luma = '0;
`endif
endmodule

// File: tb/tb_gray_control.sv
// tb_gray_control: randomized frames against a formula-level luma model for gray_control.
module tb_gray_control;
  localparam int DEPTH = 1024;
  localparam int AB = $clog2(DEPTH);
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ack_read = 1'b0;
  logic ack_write = 1'b0;
  logic rq_read, reading, read_clk, rq_write, writing, write_en, write_clk, enable_mem, frame_done;
  logic [14:0] input_px_rgb, output_px_gray;
  logic [AB-1:0] read_addr, write_addr;
  logic [4:0] peak_luma;
  logic [14:0] mem [DEPTH];
  logic [14:0] wr_log [DEPTH];
  int ntot = 0;
  int npass = 0;
  int nfail = 0;
  int exp_peak = 0;

  gray_control #(.DEPTH(DEPTH)) dut (
    .gray_clk(clk), .reset_n(reset_n),
    .ack_read(ack_read), .rq_read(rq_read), .reading(reading),
    .input_px_rgb(input_px_rgb), .read_addr(read_addr), .read_clk(read_clk),
    .ack_write(ack_write), .rq_write(rq_write), .writing(writing),
    .output_px_gray(output_px_gray), .write_addr(write_addr), .write_en(write_en),
    .write_clk(write_clk), .enable_mem(enable_mem), .frame_done(frame_done),
    .peak_luma(peak_luma)
  );

  always #5 clk = ~clk;
  always @(posedge clk) input_px_rgb <= mem[read_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int luma(input logic [14:0] p);
    return (77 * int'(p[14:10]) + 150 * int'(p[9:5]) + 29 * int'(p[4:0])) / 256;
  endfunction

  function automatic logic [14:0] gray(input logic [14:0] p);
    logic [4:0] y;
    y = 5'(luma(p));
    return {y, y, y};
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
  endtask

  task automatic start();
    ack_read = 1'b0;
    ack_write = 1'b0;
    @(negedge clk);
    chk("req_rq_read", 32'(rq_read), 1);
    chk("req_rq_write", 32'(rq_write), 1);
    chk("req_enable_mem", 32'(enable_mem), 0);
    chk("req_write_en", 32'(write_en), 0);
  endtask

  task automatic run_frame();
    int pk;
    bit we;
    pk = 0;
    ack_read = 1'b1;
    ack_write = 1'b1;
    @(negedge clk);
    chk("reading", 32'(reading), 1);
    chk("writing", 32'(writing), 1);
    for (int c = 0; c <= DEPTH + 3; c++) begin
      we = (c >= 2) && (c <= DEPTH + 1);
      if (c < DEPTH) chk("read_addr", 32'(read_addr), c);
      if (c <= DEPTH + 1) begin
        chk("rq_read", 32'(rq_read), 1);
        chk("enable_mem", 32'(enable_mem), 1);
      end
      chk("write_en", 32'(write_en), 32'(we));
      if (we) begin
        chk("write_addr", 32'(write_addr), c - 2);
        chk("gray_data", 32'(output_px_gray), 32'(gray(mem[c - 2])));
        wr_log[c - 2] = output_px_gray;
        if (luma(mem[c - 2]) > pk) pk = luma(mem[c - 2]);
      end
      chk("frame_done", 32'(frame_done), 32'(c == DEPTH + 2));
      if (c == DEPTH + 2) begin
        chk("done_rq_read", 32'(rq_read), 0);
        chk("done_rq_write", 32'(rq_write), 0);
        chk("done_enable_mem", 32'(enable_mem), 0);
        chk("done_read_addr", 32'(read_addr), 0);
      end
      if (c == DEPTH + 3) begin
`ifdef GRAY_PEAK_EN
        exp_peak = pk;
`else
        exp_peak = 0;
`endif
        chk("peak_luma", 32'(peak_luma), exp_peak);
        chk("gray_hold", 32'(output_px_gray), 32'(gray(mem[DEPTH - 1])));
      end
      if (c < DEPTH + 3) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rq_read", 32'(rq_read), 0);
    chk("rst_enable_mem", 32'(enable_mem), 0);
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_read_addr", 32'(read_addr), 0);
    chk("rst_gray", 32'(output_px_gray), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_peak", 32'(peak_luma), 0);
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) mem[i] = 15'h7FFF;
    start();
    run_frame();
    chk("white_first", 32'(wr_log[0]), 32'h7FFF);
    chk("white_last", 32'(wr_log[DEPTH - 1]), 32'h7FFF);

    fill_rand();
    mem[0] = 15'h7C00;
    mem[1] = 15'h03E0;
    mem[2] = 15'h001F;
    mem[3] = 15'h0000;
    start();
    run_frame();
    chk("red_px", 32'(wr_log[0]), 32'h2529);
    chk("green_px", 32'(wr_log[1]), 32'h4A52);
    chk("blue_px", 32'(wr_log[2]), 32'h0C63);
    chk("black_px", 32'(wr_log[3]), 32'h0000);

    fill_rand();
    start();
    ack_read = 1'b1;
    ack_write = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_rq_read", 32'(rq_read), 1);
      chk("stall_rq_write", 32'(rq_write), 1);
      chk("stall_read_addr", 32'(read_addr), 0);
      chk("stall_enable_mem", 32'(enable_mem), 0);
      chk("stall_write_en", 32'(write_en), 0);
      chk("stall_reading", 32'(reading), 1);
      chk("stall_writing", 32'(writing), 0);
    end
    run_frame();

    fill_rand();
    start();
    ack_read = 1'b1;
    ack_write = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 1000; c++) begin
      chk("abort_read_addr", 32'(read_addr), c);
      if (c < 1000) @(negedge clk);
    end
    ack_read = 1'b0;
    @(negedge clk);
    chk("abort_rq_read", 32'(rq_read), 0);
    chk("abort_rq_write", 32'(rq_write), 0);
    chk("abort_enable_mem", 32'(enable_mem), 0);
    chk("abort_write_en", 32'(write_en), 0);
    chk("abort_read_addr0", 32'(read_addr), 0);
    chk("abort_write_addr0", 32'(write_addr), 0);
    repeat (5) begin
      chk("abort_frame_done", 32'(frame_done), 0);
      chk("abort_idle_rq", 32'(rq_read), 0);
      chk("abort_peak", 32'(peak_luma), exp_peak);
      @(negedge clk);
    end
    start();
    run_frame();

    fill_rand();
    start();
    ack_read = 1'b1;
    ack_write = 1'b1;
    repeat (51) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_rq_read", 32'(rq_read), 0);
    chk("arst_rq_write", 32'(rq_write), 0);
    chk("arst_reading", 32'(reading), 0);
    chk("arst_writing", 32'(writing), 0);
    chk("arst_enable_mem", 32'(enable_mem), 0);
    chk("arst_write_en", 32'(write_en), 0);
    chk("arst_read_addr", 32'(read_addr), 0);
    chk("arst_write_addr", 32'(write_addr), 0);
    chk("arst_gray", 32'(output_px_gray), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    chk("arst_peak", 32'(peak_luma), 0);
    exp_peak = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_wait_rq", 32'(rq_read), 0);
      chk("arst_wait_enable", 32'(enable_mem), 0);
    end
    start();

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[$urandom_range(DEPTH - 1, 0)] = 15'h7FFF;
    run_frame();
`ifdef GRAY_PEAK_EN
    chk("peak_single", 32'(peak_luma), 31);
`else
    chk("peak_single", 32'(peak_luma), 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/gray_control.md
# gray_control

Grayscale conversion stage directly upstream of the Sobel stage. Each frame, it reads RGB555 pixels from the capture frame buffer and converts each one to a 5-bit luma value. It replicates that luma into a 15-bit gray word and writes it to the gray buffer that the Sobel stage later reads. Buffer access uses the same request/acknowledge arbitration as the other preprocessing stages.

## Interface
Parameters:
- `DEPTH`, 76800, pixels per frame (320x240)
- `ADDR_BITS`, `$clog2(DEPTH)`, address width

Ports (one clock; reset is asynchronous and active-low):
- `gray_clk` in 1: stage clock; also drives buffer clocks
- `reset_n` in 1: asynchronous active-low reset
- `ack_read` in 1: capture-buffer grant
- `rq_read` out 1: capture-buffer request
- `reading` out 1: `rq_read & ack_read`
- `input_px_rgb` in 15: R[14:10], G[9:5], B[4:0]; synchronous read, valid one cycle after `read_addr`
- `read_addr` out ADDR_BITS: capture-buffer address
- `read_clk` out 1: `gray_clk`
- `ack_write` in 1: gray-buffer grant
- `rq_write` out 1: gray-buffer request
- `writing` out 1: `rq_write & ack_write`
- `output_px_gray` out 15: `{Y,Y,Y}`
- `write_addr` out ADDR_BITS: gray-buffer address
- `write_en` out 1: write strobe
- `write_clk` out 1: `gray_clk`
- `enable_mem` out 1: high while the stage owns both buffers
- `frame_done` out 1: one-cycle pulse when a frame completes
- `peak_luma` out 5: maximum Y of the last completed frame (see Configuration)

## Operation
- All registered outputs reset to 0, FSM resets to IDLE.
- FSM states: IDLE, REQUEST, PROCESS, FLUSH, DONE.
- IDLE -> REQUEST when `ack_read==0 && ack_write==0`. Otherwise stay in IDLE.
- REQUEST:
  - `rq_read = rq_write = 1`.
  - When both acks are high in the same cycle, go to PROCESS.
  - In that transition, `enable_mem <= 1` and `read_addr <= 0`.
- PROCESS:
  - `read_addr` increments by 1 per cycle through DEPTH-1.
  - The cycle after issuing DEPTH-1, go to FLUSH.
- FLUSH: 2 cycles with no new reads, draining the pipeline. Then go to DONE.
- DONE: for 1 cycle:
  - `frame_done = 1`
  - `rq_read`, `rq_write`, `enable_mem` cleared
  - `read_addr` reset to 0
  - next state IDLE
- Conversion:
  - `Y = (77*R + 150*G + 29*B) >> 8`, computed with 13-bit unsigned intermediate.
  - Maximum sum is 7936, so Y ≤ 31 and no saturation is needed.
- Abort:
  - If `ack_read` or `ack_write` falls in PROCESS or FLUSH, drop both requests and clear `enable_mem` and `write_en`.
  - Reset both address counters and return to IDLE.
  - No `frame_done` pulse. The next frame restarts at address 0.
- Asynchronous reset mid-frame: all state is cleared immediately, with the same effect as abort.

## Timing
- Pipeline, relative to `read_addr = k` in cycle t:
  - t+1: `input_px_rgb` valid, registered.
  - t+2: `output_px_gray`, `write_addr = k`, `write_en = 1`, all registered.
- Latency is 2 cycles address-to-write. Throughput is 1 pixel/cycle.
- The first write occurs 2 cycles after entering PROCESS.
- The last write (address DEPTH-1) occurs in the second FLUSH cycle.
- `frame_done` fires in the cycle after the last write.
- Frame duration from REQUEST exit to `frame_done` is DEPTH+3 cycles.
- `write_en` is 0 in IDLE, REQUEST and DONE.
- `output_px_gray` holds its last value when `write_en == 0`.
- Address counters wrap at DEPTH-1 only via DONE. They never exceed DEPTH-1.

## Configuration
Macro: `GRAY_PEAK_EN`.
- Defined:
  - A 5-bit running-max register updates on every `write_en` cycle.
  - It is copied to `peak_luma` in DONE, then cleared for the next frame.
  - Abort clears the running max without updating `peak_luma`.
- Undefined: `peak_luma` is tied to 0 and no tracking logic is present.

## Test plan
- Constant 0x7FFF frame, acks granted -> every write 0x7FFF, addresses 0..DEPTH-1 in order, `frame_done` pulse once.
- Pixels 0x7C00 / 0x03E0 / 0x001F / 0x0000 at addresses 0..3 -> writes 0x2529 / 0x4A52 / 0x0C63 / 0x0000 at addresses 0..3, each 2 cycles after its read.
- `ack_write` held low in REQUEST for 10 cycles -> stays in REQUEST with both rq high, no reads advance; processing starts once both acks are high.
- `ack_read` dropped at address 1000 -> both rq low next cycle, no `frame_done`. After re-grant, the frame restarts from address 0.
- `reset_n` pulsed low mid-PROCESS -> all outputs 0 immediately; the FSM re-enters IDLE and waits for both acks low.
- With `GRAY_PEAK_EN` defined, a frame of 0x0000 except one 0x7FFF pixel -> `peak_luma = 31` after `frame_done`. With the macro undefined -> `peak_luma = 0`.
